sa_result_drain: RTL and testbench

- Read-side counterpart of the 4x8 systolic PE array. It drains the array's result outputs so that downstream logic can consume them.
- Each PE exposes three 2N-bit results (matrix slots 0..2). All of them arrive on one flattened bus and are snapshotted in a single cycle.
- The snapshot is then streamed out one word per cycle over a valid/ready interface, in PE port order.
- Decouples the array's free-running accumulators from a narrow, back-pressured consumer such as a memory writer or bus bridge.

---
 rtl/sa_result_drain.sv | 116 +++++++++++
 tb/tb_sa_result_drain.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_result_drain.sv
// Snapshot-and-stream drain for the systolic PE array result outputs.
// Optional output ReLU: define SA_DRAIN_RELU_EN.
module sa_result_drain #(
   parameter int N    = 8,
   parameter int ROWS = 4,
   parameter int COLS = 8,
   parameter int MATS = 3,
   localparam int W     = 2 * N,
   localparam int TOTAL = MATS * ROWS * COLS,
   localparam int IW    = $clog2(TOTAL)
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [TOTAL*W-1:0] res_flat_i,
   input  logic               cap_valid_i,
   output logic               cap_ready_o,
   output logic               m_valid_o,
   input  logic               m_ready_i,
   output logic [W-1:0]       m_data_o,
   output logic [IW-1:0]      m_idx_o,
   output logic               m_last_o,
   output logic               busy_o,
   output logic               frame_done_o
);

   typedef enum logic {
      IDLE,
      STREAM
   } state_t;

   localparam logic [IW-1:0] LAST = IW'(TOTAL - 1);

   state_t             state_q;
   logic [IW-1:0]      ptr_q;
   logic [IW-1:0]      ptr_d;
   logic               valid_q;
   logic               last_q;
   logic               busy_q;
   logic               done_q;
   logic [TOTAL*W-1:0] shadow_q;
   logic [W-1:0]       word;
   logic [W-1:0]       data_d;
   logic               cap_hs;

   assign ptr_d  = ptr_q + 1'b1;
   assign cap_hs = (state_q == IDLE) && cap_valid_i;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (cap_valid_i) begin
                  state_q <= STREAM;
                  ptr_q   <= '0;
                  valid_q <= 1'b1;
                  last_q  <= (LAST == '0);
                  busy_q  <= 1'b1;
               end
            end
            STREAM: begin
               if (m_ready_i) begin
                  if (ptr_q == LAST) begin
                     state_q <= IDLE;
                     ptr_q   <= '0;
                     valid_q <= 1'b0;
                     last_q  <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     ptr_q  <= ptr_d;
                     last_q <= (ptr_d == LAST);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Shadow is written only on a capture handshake; reset leaves it stale.
   always_ff @(posedge clk_i) begin
      if (!reset_i && cap_hs) begin
         shadow_q <= res_flat_i;
      end
   end

   assign word = shadow_q[int'(ptr_q)*W +: W];

   always_comb begin
      data_d = '0;
      if (valid_q) begin
`ifdef SA_DRAIN_RELU_EN
         data_d = word[W-1] ? '0 : word;
`else
         data_d = word;
`endif
      end
   end

   assign cap_ready_o  = (state_q == IDLE);
   assign m_valid_o    = valid_q;
   assign m_data_o     = data_d;
   assign m_idx_o      = ptr_q;
   assign m_last_o     = last_q;
   assign busy_o       = busy_q;
   assign frame_done_o = done_q;

endmodule

// File: tb/tb_sa_result_drain.sv
// Scoreboard bench for sa_result_drain: directed frames, back-pressure,
// snapshot isolation, mid-frame reset, back-to-back capture, ReLU build.
module tb_sa_result_drain;

   localparam int TOTAL = 96;
   localparam int W     = 16;
   localparam int IW    = 7;

   typedef struct packed {
      logic [W-1:0]  d;
      logic [IW-1:0] i;
      logic          l;
   } exp_t;

   logic               clk;
   logic               reset;
   logic [TOTAL*W-1:0] res_flat;
   logic               cap_valid;
   logic               cap_ready;
   logic               m_valid;
   logic               m_ready;
   logic [W-1:0]       m_data;
   logic [IW-1:0]      m_idx;
   logic               m_last;
   logic               busy;
   logic               frame_done;

   int   total;
   int   bad;
   int   done_cnt;
   exp_t exp_q[$];

   sa_result_drain dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .res_flat_i  (res_flat),
      .cap_valid_i (cap_valid),
      .cap_ready_o (cap_ready),
      .m_valid_o   (m_valid),
      .m_ready_i   (m_ready),
      .m_data_o    (m_data),
      .m_idx_o     (m_idx),
      .m_last_o    (m_last),
      .busy_o      (busy),
      .frame_done_o(frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got=0x%0h want=0x%0h", name, got, want);
      end
   endtask

   function automatic logic [W-1:0] relu(input logic [W-1:0] w);
`ifdef SA_DRAIN_RELU_EN
      return w[W-1] ? '0 : w;
`else
      return w;
`endif
   endfunction

   // Monitor: pop and compare on every beat, check stall stability.
   logic          stall_q;
   logic [W-1:0]  pd;
   logic [IW-1:0] pi;
   initial stall_q = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (frame_done) done_cnt++;
      if (stall_q) begin
         chk("stall_valid", int'(m_valid), 1);
         chk("stall_data", int'(m_data), int'(pd));
         chk("stall_idx", int'(m_idx), int'(pi));
      end
      stall_q = m_valid && !m_ready && !reset;
      pd = m_data;
      pi = m_idx;
      if (m_valid && m_ready && !reset) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_beat", int'(m_idx), -1);
         end else begin
            e = exp_q.pop_front();
            chk("beat_data", int'(m_data), int'(e.d));
            chk("beat_idx", int'(m_idx), int'(e.i));
            chk("beat_last", int'(m_last), int'(e.l));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input logic [W-1:0] base);
      for (int k = 0; k < TOTAL; k++) res_flat[k*W +: W] = base + W'(k);
   endtask

   task automatic push_frame();
      exp_t e;
      for (int k = 0; k < TOTAL; k++) begin
         e.d = relu(res_flat[k*W +: W]);
         e.i = IW'(k);
         e.l = (k == TOTAL - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic capture();
      push_frame();
      cap_valid = 1'b1;
      tick();
      cap_valid = 1'b0;
      chk("cap_m_valid", int'(m_valid), 1);
      chk("cap_m_idx", int'(m_idx), 0);
      chk("cap_ready_low", int'(cap_ready), 0);
      chk("cap_busy", int'(busy), 1);
   endtask

   // Drain until frame_done; mode 1 = 1,0,0,1 ready, mode 2 = cap pokes.
   task automatic drain(input int mode, output int vcyc);
      int cyc;
      cyc  = 0;
      vcyc = 0;
      while (!frame_done && cyc < 600) begin
         if (m_valid) vcyc++;
         m_ready   = (mode == 1) ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
         cap_valid = (mode == 2) && ((cyc % 7) == 3);
         if (mode == 2 && m_valid) chk("stream_cap_ready", int'(cap_ready), 0);
         tick();
         cyc++;
      end
      cap_valid = 1'b0;
      m_ready   = 1'b1;
      chk("drain_timeout", int'(cyc < 600), 1);
   endtask

   initial begin
      int v;
      int d0;
      total     = 0;
      bad       = 0;
      done_cnt  = 0;
      reset     = 1'b1;
      cap_valid = 1'b0;
      m_ready   = 1'b1;
      res_flat  = '0;
      tick();
      tick();
      chk("rst_cap_ready", int'(cap_ready), 1);
      chk("rst_m_valid", int'(m_valid), 0);
      chk("rst_m_data", int'(m_data), 0);
      chk("rst_m_idx", int'(m_idx), 0);
      chk("rst_m_last", int'(m_last), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(frame_done), 0);
      reset = 1'b0;
      tick();

      // Basic drain
      fill(16'h0100);
      d0 = done_cnt;
      capture();
      drain(0, v);
      chk("basic_valid_cycles", v, TOTAL);
      chk("basic_done_valid", int'(m_valid), 0);
      chk("basic_done_ready", int'(cap_ready), 1);
      chk("basic_done_busy", int'(busy), 0);
      tick();
      chk("basic_done_pulse", int'(frame_done), 0);
      chk("basic_done_count", done_cnt - d0, 1);

      // Back-pressure
      capture();
      drain(1, v);
      chk("bp_done_ready", int'(cap_ready), 1);
      tick();

      // Snapshot isolation
      fill(16'h0200);
      capture();
      res_flat = '1;
      drain(2, v);
      chk("snap_valid_cycles", v, TOTAL);
      tick();
      tick();
      chk("snap_no_refire", int'(m_valid), 0);
      chk("snap_idle_ready", int'(cap_ready), 1);

      // Reset mid-frame after word 40 is accepted
      fill(16'h0300);
      capture();
      for (int k = 0; k < 41; k++) tick();
      chk("mid_idx", int'(m_idx), 41);
      d0      = done_cnt;
      m_ready = 1'b0;
      reset   = 1'b1;
      cap_valid = 1'b1;
      tick();
      cap_valid = 1'b0;
      reset   = 1'b0;
      m_ready = 1'b1;
      exp_q.delete();
      chk("mid_rst_valid", int'(m_valid), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_ready", int'(cap_ready), 1);
      chk("mid_rst_done", int'(frame_done), 0);
      tick();
      chk("mid_rst_no_cap", int'(m_valid), 0);
      chk("mid_rst_done_cnt", done_cnt - d0, 0);
      capture();
      drain(0, v);
      chk("mid_restart_cycles", v, TOTAL);
      tick();

      // Back-to-back frames with cap_valid held high
      fill(16'h0400);
      push_frame();
      push_frame();
      cap_valid = 1'b1;
      tick();
      for (int f = 0; f < 2; f++) begin
         v = 0;
         while (!frame_done && v < 300) begin
            tick();
            v++;
         end
         chk("b2b_timeout", int'(v < 300), 1);
         chk("b2b_gap_valid", int'(m_valid), 0);
         chk("b2b_gap_ready", int'(cap_ready), 1);
         if (f == 1) cap_valid = 1'b0;
         tick();
         chk("b2b_next_valid", int'(m_valid), (f == 0) ? 1 : 0);
         if (f == 0) chk("b2b_next_idx", int'(m_idx), 0);
      end
      tick();

      // ReLU boundary words
      fill(16'h0100);
      res_flat[0*W +: W] = 16'h8001;
      res_flat[1*W +: W] = 16'h7FFF;
      capture();
`ifdef SA_DRAIN_RELU_EN
      chk("relu_word0", int'(m_data), 16'h0000);
`else
      chk("relu_word0", int'(m_data), 16'h8001);
`endif
      tick();
      chk("relu_word1", int'(m_data), 16'h7FFF);
      drain(0, v);
      tick();
      tick();
      chk("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
